// File: rtl/audio_udp_frame_packer.sv
// Packs pairs of 16-bit ADC samples into 32-bit words, buffers them in a circular RAM
// and streams full frames to the UDP core. Define AUDIO_PKT_HEADER_EN to prefix each frame with a header word.
module audio_udp_frame_packer #(
  parameter int          FRAME_WORDS  = 256,
  parameter int          ADDR_W       = 9,
  parameter logic [23:0] DONE_TIMEOUT = 24'd5_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        audio_en,
  input  logic [15:0] audio_data,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] FRAME_C = (ADDR_W + 1)'(FRAME_WORDS);
`ifdef AUDIO_PKT_HEADER_EN
  localparam logic [15:0]     BYTE_NUM = 16'(FRAME_WORDS * 4 + 4);
`else
  localparam logic [15:0]     BYTE_NUM = 16'(FRAME_WORDS * 4);
`endif

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d, sent_cnt_q, sent_cnt_d;
  logic              half_q, half_d;
  logic [15:0]       hi_q, hi_d;
  logic              tx_start_en_q, tx_start_en_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [23:0]       timeout_q, timeout_d;
`ifdef AUDIO_PKT_HEADER_EN
  logic              hdr_q, hdr_d;
`endif
  logic              wr_en, rd_en;
  logic [31:0]       rd_word;
  logic [31:0]       mem [DEPTH];

  assign rd_word = mem[rd_ptr_q];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the block infers a latch.
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    word_cnt_d    = word_cnt_q;
    sent_cnt_d    = sent_cnt_q;
    half_d        = half_q;
    hi_d          = hi_q;
    tx_start_en_d = 1'b0;
    tx_data_d     = tx_data_q;
    overflow_d    = overflow_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_d     = timeout_q;
`ifdef AUDIO_PKT_HEADER_EN
    hdr_d         = hdr_q;
`endif
    wr_en         = 1'b0;
    rd_en         = 1'b0;

    // The half-word latch toggles even on a dropped word so sample pairing never slips.
    if (audio_en) begin
      half_d = ~half_q;
      if (!half_q)                   hi_d       = audio_data;
      else if (word_cnt_q == DEPTH_C) overflow_d = 1'b1;
      else                           wr_en      = 1'b1;
    end

    unique case (state_q)
      IDLE: if (word_cnt_q >= FRAME_C) begin
        state_d       = START;
        tx_start_en_d = 1'b1;
      end
      START: begin
        sent_cnt_d = '0;
`ifdef AUDIO_PKT_HEADER_EN
        hdr_d      = 1'b1;
`endif
        state_d    = SEND;
      end
      SEND: if (tx_req) begin
`ifdef AUDIO_PKT_HEADER_EN
        if (hdr_q) begin
          tx_data_d = {16'hA55A, frame_cnt_q};
          hdr_d     = 1'b0;
        end else begin
          rd_en = 1'b1;
        end
`else
        rd_en = 1'b1;
`endif
        if (rd_en) begin
          tx_data_d  = rd_word;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          sent_cnt_d = sent_cnt_q + 1'b1;
          if (sent_cnt_d == FRAME_C) begin
            state_d   = WAIT_DONE;
            timeout_d = '0;
          end
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end else if (timeout_q == DONE_TIMEOUT - 24'd1) begin
          state_d = IDLE;
        end else begin
          timeout_d = timeout_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   word_cnt_d = word_cnt_q + 1'b1;
      2'b01:   word_cnt_d = word_cnt_q - 1'b1;
      default: word_cnt_d = word_cnt_q;
    endcase
  end

  // NOTE: the sample RAM has no reset; the pointers and word count define which entries are valid.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q] <= {hi_q, audio_data};
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      word_cnt_q    <= '0;
      sent_cnt_q    <= '0;
      half_q        <= 1'b0;
      hi_q          <= '0;
      tx_start_en_q <= 1'b0;
      tx_data_q     <= '0;
      overflow_q    <= 1'b0;
      frame_cnt_q   <= '0;
      timeout_q     <= '0;
`ifdef AUDIO_PKT_HEADER_EN
      hdr_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      word_cnt_q    <= word_cnt_d;
      sent_cnt_q    <= sent_cnt_d;
      half_q        <= half_d;
      hi_q          <= hi_d;
      tx_start_en_q <= tx_start_en_d;
      tx_data_q     <= tx_data_d;
      overflow_q    <= overflow_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_q     <= timeout_d;
`ifdef AUDIO_PKT_HEADER_EN
      hdr_q         <= hdr_d;
`endif
    end
  end

  assign tx_start_en = tx_start_en_q;
  assign tx_byte_num = BYTE_NUM;
  assign tx_data     = tx_data_q;
  assign overflow    = overflow_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_audio_udp_frame_packer.sv
// Directed-sequence bench with random sample data, checked against a queue model of the frame buffer.
module tb_audio_udp_frame_packer;

  localparam int FW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef AUDIO_PKT_HEADER_EN
  localparam logic [15:0] BYTES = 16'(FW * 4 + 4);
`else
  localparam logic [15:0] BYTES = 16'(FW * 4);
`endif

  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        audio_en = 1'b0, tx_req = 1'b0, tx_done = 1'b0;
  logic [15:0] audio_data = '0;
  logic        tx_start_en, overflow;
  logic [15:0] tx_byte_num, frame_cnt;
  logic [31:0] tx_data;

  audio_udp_frame_packer #(.FRAME_WORDS(FW), .ADDR_W(AW), .DONE_TIMEOUT(24'd40)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .audio_en(audio_en), .audio_data(audio_data),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .tx_done(tx_done), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_err = 0, start_seen = 0;
  always @(posedge sys_clk) if (tx_start_en === 1'b1) start_seen++;

  // Reference model: FIFO of packed words plus the half-word pairing state.
  logic [31:0] mq[$];
  bit          m_half = 1'b0;
  logic [15:0] m_hi = '0;
  logic [15:0] m_frames = '0;
  logic [31:0] m_last = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_sample(input logic [15:0] s);
    if (!m_half) begin
      m_hi = s; m_half = 1'b1;
    end else begin
      m_half = 1'b0;
      if (mq.size() < DEPTH) mq.push_back({m_hi, s});
    end
  endtask

  task automatic tick_sample(input logic [15:0] s, input bit req);
    @(negedge sys_clk);
    audio_en = 1'b1; audio_data = s; tx_req = req;
    @(posedge sys_clk); #1;
    audio_en = 1'b0; tx_req = 1'b0;
  endtask

  task automatic send_rand(input int n);
    logic [15:0] s;
    for (int i = 0; i < n; i++) begin
      s = 16'($urandom);
      tick_sample(s, 1'b0);
      model_sample(s);
    end
  endtask

  task automatic wait_start(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge sys_clk);
      if (tx_start_en === 1'b1) begin got = 1'b1; break; end
    end
    check({tag, "_start"}, 32'(got), 32'd1);
    check({tag, "_bytes"}, 32'(tx_byte_num), 32'(BYTES));
  endtask

  task automatic read_word(input string tag);
    logic [31:0] exp;
    @(negedge sys_clk); tx_req = 1'b1;
    @(posedge sys_clk); #1; tx_req = 1'b0;
    exp = (mq.size() > 0) ? mq.pop_front() : 32'hDEAD_BEEF;
    m_last = exp;
    @(negedge sys_clk);
    check(tag, tx_data, exp);
  endtask

  task automatic read_hdr(input string tag);
`ifdef AUDIO_PKT_HEADER_EN
    @(negedge sys_clk); tx_req = 1'b1;
    @(posedge sys_clk); #1; tx_req = 1'b0;
    m_last = {16'hA55A, m_frames};
    @(negedge sys_clk);
    check({tag, "_hdr"}, tx_data, m_last);
`else
    m_last = m_last;
`endif
  endtask

  task automatic do_done(input string tag);
    @(negedge sys_clk); tx_done = 1'b1;
    @(posedge sys_clk); #1; tx_done = 1'b0;
    m_frames++;
    @(negedge sys_clk);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_en"}, 32'(tx_start_en), 32'd0);
    check({tag, "_bytes"},    32'(tx_byte_num), 32'(BYTES));
    check({tag, "_tx_data"},  tx_data, 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [15:0] s;
    int starts;

    // Reset state
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_outputs("reset");

    // Directed first frame: samples 1..8
    for (int i = 1; i <= 8; i++) begin
      tick_sample(16'(i), 1'b0);
      model_sample(16'(i));
    end
    wait_start("f1");
    read_hdr("f1");
    for (int i = 0; i < FW; i++) read_word($sformatf("f1_w%0d", i));
    check("f1_last_word", m_last, 32'h0007_0008);
    check("f1_one_start", 32'(start_seen), 32'd1);
    do_done("f1");

    // tx_req outside SEND must not disturb tx_data
    @(negedge sys_clk); tx_req = 1'b1;
    @(posedge sys_clk); #1; tx_req = 1'b0;
    @(negedge sys_clk);
    check("idle_req_hold", tx_data, 32'h0007_0008);

    // Overflow: 18 samples with no reads, 9th word dropped
    send_rand(18);
    @(negedge sys_clk);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_word_cnt", 32'(dut.word_cnt_q), 32'(mq.size()));
    check("ovf_start", 32'(start_seen), 32'd2);
    read_hdr("ovf_a");
    for (int i = 0; i < FW; i++) read_word($sformatf("ovf_a_w%0d", i));

    // No tx_done: the frame times out without counting
    repeat (30) @(negedge sys_clk);
    check("to_no_restart", 32'(start_seen), 32'd2);
    wait_start("to");
    check("to_frame_cnt", 32'(frame_cnt), 32'(m_frames));
    read_hdr("ovf_b");
    for (int i = 0; i < FW; i++) read_word($sformatf("ovf_b_w%0d", i));
    do_done("ovf_b");

    // Simultaneous write and read with 5 words buffered
    send_rand(10);
    repeat (3) @(negedge sys_clk);
    read_hdr("sim");
    send_rand(1);
    s = 16'($urandom);
    tick_sample(s, 1'b1);
    exp_w = mq.pop_front();
    model_sample(s);
    @(negedge sys_clk);
    check("sim_data", tx_data, exp_w);
    check("sim_word_cnt", 32'(dut.word_cnt_q), 32'd5);
    for (int i = 1; i < FW; i++) read_word($sformatf("sim_w%0d", i));
    do_done("sim");

    // Reset in the middle of SEND
    send_rand(4);
    wait_start("mid");
    read_hdr("mid");
    read_word("mid_w0");
    @(negedge sys_clk); sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_reset_outputs("midrst");
    check("midrst_word_cnt", 32'(dut.word_cnt_q), 32'd0);
    sys_rst = 1'b0;
    mq.delete(); m_half = 1'b0; m_frames = '0;
    starts = start_seen;
    send_rand(6);
    repeat (20) @(negedge sys_clk);
    check("midrst_no_start", 32'(start_seen), 32'(starts));
    send_rand(2);
    wait_start("post");
    read_hdr("post");
    for (int i = 0; i < FW; i++) read_word($sformatf("post_w%0d", i));
    do_done("post");

    // Random frames with random request gaps
    for (int f = 0; f < 3; f++) begin
      send_rand(8);
      wait_start($sformatf("rnd%0d", f));
      read_hdr($sformatf("rnd%0d", f));
      for (int i = 0; i < FW; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        read_word($sformatf("rnd%0d_w%0d", f, i));
      end
      do_done($sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
